hf_conf_rx: RTL and testbench

//  Upstream config stage for the HF top level: receives the ARM's 16-bit SPI command words and

---
 rtl/hf_conf_rx_if.sv | 26 ++
 rtl/hf_conf_rx.sv | 131 +++++++++++++
 tb/tb_hf_conf_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hf_conf_rx_if.sv
// SPI command pins from the ARM plus the configuration outputs of hf_conf_rx.
// The master side drives the SPI pins. The slave side is the receiver and drives the config outputs.
interface hf_conf_rx_if;
    logic       spck;
    logic       mosi;
    logic       ncs;
    logic [7:0] conf_word;
    logic [2:0] major_mode;
    logic       conf_valid;
    logic       mode_guard;
    logic       cmd_err;
    logic [7:0] err_cnt;
    logic [1:0] dbg_state;

    // Handshake: conf_valid and cmd_err are single-cycle pulses with no ready/backpressure.
    // conf_word is stable whenever conf_valid is low.
    modport master (
        output spck, mosi, ncs,
        input  conf_word, major_mode, conf_valid, mode_guard, cmd_err, err_cnt, dbg_state
    );

    modport slave (
        input  spck, mosi, ncs,
        output conf_word, major_mode, conf_valid, mode_guard, cmd_err, err_cnt, dbg_state
    );
endinterface

// File: rtl/hf_conf_rx.sv
// HF config receiver: resamples the ARM's SPI frames into ck_1356meg and decodes 16-bit commands
// into the 8-bit configuration word. Major-mode changes are flagged with a guard window.
module hf_conf_rx #(
    parameter int SYNC_STAGES  = 2,
    parameter int WORD_BITS    = 16,
    parameter int GUARD_CYCLES = 8
) (
    input  logic        ck_1356meg,
    input  logic        nrst,
    hf_conf_rx_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } state_t;

    localparam logic [4:0] WORD_BITS_C = 5'(WORD_BITS);
    localparam logic [7:0] GUARD_C     = 8'(GUARD_CYCLES);

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] spck_sync, ncs_sync, mosi_sync, primed;
    logic spck_d, ncs_d, armed;
    logic spck_s, ncs_s, mosi_s;
    logic spck_rise, ncs_rise, ncs_fall;

    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic [7:0]  conf_word, err_cnt, guard_cnt;
    logic        conf_valid, cmd_err;
    logic        start_frame, shift_en, do_write, do_err, mode_change;

    assign spck_s = spck_sync[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // armed only goes high once a post-reset sample of ncs=1 reaches the last stage. A frame
    // that was already running when reset released therefore never looks like a fresh start.
    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            spck_sync <= '0;
            ncs_sync  <= '1;
            mosi_sync <= '0;
            primed    <= '0;
            spck_d    <= 1'b0;
            ncs_d     <= 1'b1;
            armed     <= 1'b0;
        end else begin
            spck_sync <= {spck_sync[SYNC_STAGES-2:0], bus.spck};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], bus.ncs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            primed    <= {primed[SYNC_STAGES-2:0], 1'b1};
            spck_d    <= spck_s;
            ncs_d     <= ncs_s;
            armed     <= armed | (primed[SYNC_STAGES-1] & ncs_s);
        end
    end

    assign spck_rise = spck_s & ~spck_d;
    assign ncs_rise  = ncs_s & ~ncs_d;
    assign ncs_fall  = ~ncs_s & ncs_d & armed;

    always_ff @(posedge ck_1356meg) begin
        if (!nrst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ncs_fall) state_next = SHIFT;
            SHIFT:   if (ncs_rise) state_next = DECODE;
            DECODE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start_frame = 1'b0;
        shift_en    = 1'b0;
        do_write    = 1'b0;
        do_err      = 1'b0;
        case (state)
            IDLE:   start_frame = ncs_fall;
            SHIFT:  shift_en    = spck_rise;
            DECODE: begin
                do_err   = (bit_cnt != WORD_BITS_C);
                do_write = (bit_cnt == WORD_BITS_C) && (shift_reg[15:12] == 4'b0001);
            end
            default: ;
        endcase
    end

    assign mode_change = do_write && (shift_reg[7:5] != conf_word[7:5]);

    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            conf_word  <= 8'hE0;
            conf_valid <= 1'b0;
            cmd_err    <= 1'b0;
            err_cnt    <= '0;
            guard_cnt  <= '0;
        end else begin
            conf_valid <= do_write;
            cmd_err    <= do_err;
            if (start_frame) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[14:0], mosi_s};
                if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            end
            if (do_write) conf_word <= shift_reg[7:0];
            if (do_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            // A reload wins over the countdown so back-to-back mode swaps extend the blanking.
            if (mode_change)         guard_cnt <= GUARD_C;
            else if (guard_cnt != 0) guard_cnt <= guard_cnt - 8'd1;
        end
    end

    assign bus.conf_word  = conf_word;
    assign bus.major_mode = conf_word[7:5];
    assign bus.conf_valid = conf_valid;
    assign bus.mode_guard = (guard_cnt != 8'd0);
    assign bus.cmd_err    = cmd_err;
    assign bus.err_cnt    = err_cnt;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_hf_conf_rx.sv
// Bench for hf_conf_rx: drives SPI frames, scoreboards conf_word writes, and checks errors and guard timing.
// A second instance with a long guard window shows a reload while the guard is still running.
module tb_hf_conf_rx;
    localparam int SYNC       = 2;
    localparam int GUARD      = 8;
    localparam int GUARD_LONG = 200;
    localparam int HALF       = 3;

    logic clk = 1'b0;
    logic nrst, spck, mosi, ncs;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hf_conf_rx_if bus();
    hf_conf_rx_if bus2();

    assign bus.spck  = spck;
    assign bus.mosi  = mosi;
    assign bus.ncs   = ncs;
    assign bus2.spck = spck;
    assign bus2.mosi = mosi;
    assign bus2.ncs  = ncs;

    hf_conf_rx u_dut (.ck_1356meg(clk), .nrst(nrst), .bus(bus));
    hf_conf_rx #(.GUARD_CYCLES(GUARD_LONG)) u_dut_long (.ck_1356meg(clk), .nrst(nrst), .bus(bus2));

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    int n_valid = 0, n_err = 0, extra_valid = 0;
    int last_valid_cyc = 0, last_err_cyc = 0, rise_cyc = 0;
    int guard_run = 0, last_guard_run = 0, guard_runs = 0;
    int guard_run2 = 0, last_guard_run2 = 0, last_v2 = 0, prev_v2 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and pulse/guard monitor, sampled away from the active edge
    always @(negedge clk) begin
        logic [7:0] e;
        if (nrst) begin
            if (bus.conf_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("conf_word", bus.conf_word, e);
                    check("major_mode", bus.major_mode, e[7:5]);
                end else begin
                    extra_valid++;
                end
            end
            if (bus.cmd_err) begin
                n_err++;
                last_err_cyc = cyc;
            end
            if (bus.mode_guard) begin
                if (guard_run == 0) check("guard_start_on_valid", bus.conf_valid, 1);
                guard_run++;
            end else if (guard_run != 0) begin
                last_guard_run = guard_run;
                guard_runs++;
                guard_run = 0;
            end
            if (bus2.conf_valid) begin
                prev_v2 = last_v2;
                last_v2 = cyc;
            end
            if (bus2.mode_guard) guard_run2++;
            else if (guard_run2 != 0) begin
                last_guard_run2 = guard_run2;
                guard_run2 = 0;
            end
        end
    end

    task automatic send_bits(input logic [31:0] word, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            mosi = word[i];
            repeat (HALF) @(negedge clk);
            spck = 1'b1;
            repeat (HALF) @(negedge clk);
            spck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits);
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(word, nbits - 1, 0);
        repeat (HALF) @(negedge clk);
        ncs = 1'b1;
        rise_cyc = cyc;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int e0;
        nrst = 1'b0; spck = 1'b0; mosi = 1'b0; ncs = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_conf_word", bus.conf_word, 8'hE0);
        check("rst_major_mode", bus.major_mode, 3'b111);
        check("rst_conf_valid", bus.conf_valid, 0);
        check("rst_mode_guard", bus.mode_guard, 0);
        check("rst_cmd_err", bus.cmd_err, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        check("rst_state", bus.dbg_state, 0);
        nrst = 1'b1;
        repeat (8) @(negedge clk);

        // 1: first write changes major mode -> guard for GUARD clocks
        exp_q.push_back(8'h23);
        send_frame(32'h1023, 16);
        check("t1_valid_cnt", n_valid, 1);
        check("t1_latency", last_valid_cyc - rise_cyc, SYNC + 2);
        check("t1_guard_len", last_guard_run, GUARD);
        check("t1_guard_runs", guard_runs, 1);

        // 2: same major mode -> no guard
        exp_q.push_back(8'h24);
        send_frame(32'h1024, 16);
        check("t2_valid_cnt", n_valid, 2);
        check("t2_guard_runs", guard_runs, 1);
        check("t2_conf_word", bus.conf_word, 8'h24);

        // 3: short and long frames
        send_frame(32'h0000_0123, 15);
        check("t3_err_latency", last_err_cyc - rise_cyc, SYNC + 2);
        send_frame(32'h0001_1023, 17);
        check("t3_err_pulses", n_err, 2);
        check("t3_err_cnt", bus.err_cnt, 2);
        check("t3_valid_cnt", n_valid, 2);
        check("t3_conf_word", bus.conf_word, 8'h24);

        // 4: wrong opcode is ignored
        send_frame(32'h20FF, 16);
        check("t4_valid_cnt", n_valid, 2);
        check("t4_err_pulses", n_err, 2);
        check("t4_conf_word", bus.conf_word, 8'h24);

        // 5: reset mid-frame, released with ncs low
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(32'h1060, 15, 8);
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        send_bits(32'h1060, 7, 0);
        repeat (HALF) @(negedge clk);
        ncs = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_conf_word", bus.conf_word, 8'hE0);
        check("t5_valid_cnt", n_valid, 2);
        check("t5_err_pulses", n_err, 2);
        check("t5_err_cnt", bus.err_cnt, 0);
        exp_q.push_back(8'h60);
        send_frame(32'h1060, 16);
        check("t5b_conf_word", bus.conf_word, 8'h60);
        check("t5b_valid_cnt", n_valid, 3);

        // 6: err_cnt saturation, then back-to-back mode changes
        e0 = n_err;
        repeat (300) send_frame(32'h1, 1);
        check("t6_err_cnt_sat", bus.err_cnt, 255);
        check("t6_err_pulses", n_err - e0, 300);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h40);
        send_frame(32'h10A0, 16);
        send_frame(32'h1040, 16);
        check("t6_guard_len", last_guard_run, GUARD);
        check("t6_valid_cnt", n_valid, 5);
        check("t6_conf_word", bus.conf_word, 8'h40);
        repeat (GUARD_LONG + 50) @(negedge clk);
        check("t6_long_conf_word", bus2.conf_word, 8'h40);
        check("t6_long_guard_reload", last_guard_run2, (last_v2 - prev_v2) + GUARD_LONG);
        check("exp_q_drained", exp_q.size(), 0);
        check("extra_valid", extra_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
